// File: rtl/output_port_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : output_port_ctrl_pkg
// Brief    : Shared state encoding, port indices and defaults for output_port_ctrl.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package output_port_ctrl_pkg;

   localparam int OPC_DATA_W    = 32;
   localparam int OPC_MAX_FLITS = 16;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } opc_state_t;

   localparam logic [1:0] PORT0 = 2'd0;
   localparam logic [1:0] PORT1 = 2'd1;
   localparam logic [1:0] PORT2 = 2'd2;
   localparam logic [1:0] PORT3 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/four_way_arbiter.sv
//------------------------------------------------------------------------------
// Module   : four_way_arbiter
// Brief    : Fixed-priority 4-way arbiter; lowest-numbered request wins.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module four_way_arbiter (
   input  logic       reset,
   input  logic [3:0] requests,
   output logic [1:0] granted
);

   always_comb begin
      granted = 2'd0;
      if (!reset) begin
         if (requests[0])      granted = 2'd0;
         else if (requests[1]) granted = 2'd1;
         else if (requests[2]) granted = 2'd2;
         else if (requests[3]) granted = 2'd3;
      end
   end

endmodule

`default_nettype wire

// File: rtl/output_port_ctrl.sv
//------------------------------------------------------------------------------
// Module   : output_port_ctrl
// Brief    : Wormhole output-port controller with registered valid/ready stage.
//            Define OPC_RR_MASK_EN for round-robin masking of arbiter requests.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module output_port_ctrl
   import output_port_ctrl_pkg::*;
#(
   parameter  int DATA_W    = OPC_DATA_W,
   parameter  int MAX_FLITS = OPC_MAX_FLITS,
   localparam int CNT_W     = $clog2(MAX_FLITS + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          in_valid,
   input  logic [4*DATA_W-1:0] in_data,
   input  logic [3:0]          in_last,
   output logic [3:0]          in_ready,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_last,
   input  logic                out_ready,
   output logic [1:0]          owner,
   output logic                err_overlong
);

   opc_state_t        r_state;
   opc_state_t        w_state_nxt;
   logic [1:0]        r_owner;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;
   logic              r_err;
   logic [3:0]        w_arb_req;
   logic [1:0]        w_granted;
   logic              w_any_req;
   logic              w_can_load;
   logic              w_xfer;
   logic              w_wdog;
   logic              w_pkt_end;

`ifdef OPC_RR_MASK_EN
   logic [3:0] r_mask;
   logic [3:0] w_masked;
   assign w_masked  = in_valid & r_mask;
   assign w_arb_req = (w_masked != 4'b0000) ? w_masked : in_valid;
`else
   assign w_arb_req = in_valid;
`endif

   assign w_any_req = |w_arb_req;

   four_way_arbiter u_arb (
      .reset    (~reset),
      .requests (w_arb_req),
      .granted  (w_granted)
   );

   assign w_can_load = !r_out_valid || out_ready;
   assign w_xfer     = (r_state == ST_LOCKED) && in_valid[r_owner] && w_can_load;
   assign w_cnt_inc  = r_cnt + CNT_W'(1);
   // Watchdog fires on the flit that reaches MAX_FLITS; that flit is still forwarded.
   assign w_wdog     = w_xfer && !in_last[r_owner] && (w_cnt_inc == CNT_W'(MAX_FLITS));
   assign w_pkt_end  = w_xfer && (in_last[r_owner] || w_wdog);

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 4'b0000;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) w_state_nxt = ST_LOCKED;
         end
         ST_LOCKED: begin
            in_ready[r_owner] = w_can_load;
            if (w_pkt_end) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_owner     <= PORT0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_err       <= 1'b0;
`ifdef OPC_RR_MASK_EN
         r_mask      <= 4'b1111;
`endif
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_any_req) begin
            r_owner <= w_granted;
            r_cnt   <= '0;
         end
         if (w_xfer) begin
            r_out_data  <= in_data[r_owner*DATA_W +: DATA_W];
            r_out_last  <= in_last[r_owner];
            r_out_valid <= 1'b1;
            r_cnt       <= w_cnt_inc;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_wdog) r_err <= 1'b1;
`ifdef OPC_RR_MASK_EN
         // Exclude the served input and everything below it for the next round.
         if (w_pkt_end) r_mask <= 4'b1110 << r_owner;
`endif
      end
   end

   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_last     = r_out_last;
   assign owner        = r_owner;
   assign err_overlong = r_err;

endmodule

`default_nettype wire

// File: tb/tb_output_port_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_output_port_ctrl
// Brief    : Directed, table-driven self-checking bench for output_port_ctrl.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_output_port_ctrl;

   localparam int DW = 32;
   localparam int MF = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    in_valid = '0;
   logic [4*DW-1:0] in_data = '0;
   logic [3:0]    in_last = '0;
   logic [3:0]    in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready = 1'b1;
   logic [1:0]    owner;
   logic          err_overlong;

   output_port_ctrl #(.DATA_W(DW), .MAX_FLITS(MF)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .owner        (owner),
      .err_overlong (err_overlong)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  l;
      logic        ordy;
      logic [31:0] d;
      logic [3:0]  e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      logic        e_ol;
      logic [1:0]  e_own;
      logic        e_err;
   } vec_t;

   vec_t vt[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic ordy,
                               input logic [31:0] d, input logic [3:0] e_ir, input logic e_ov,
                               input logic [31:0] e_od, input logic e_ol, input logic [1:0] e_own,
                               input logic e_err);
      vec_t r;
      r.v = v; r.l = l; r.ordy = ordy; r.d = d; r.e_ir = e_ir; r.e_ov = e_ov;
      r.e_od = e_od; r.e_ol = e_ol; r.e_own = e_own; r.e_err = e_err;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Lane i carries {i, d[27:0]} so the owner is visible in the output word.
   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
      in_valid = v;
      in_last  = l;
      for (int i = 0; i < 4; i++) in_data[i*DW +: DW] = {i[3:0], d[27:0]};
   endtask

   initial begin
      // 3-flit packet on input 2
      vt.push_back(mk(4'b0100, 4'b0000, 1, 32'd1,  4'b0000, 0, 32'h0,         0, 2'd2, 0));
      vt.push_back(mk(4'b0100, 4'b0000, 1, 32'd1,  4'b0100, 1, 32'h2000_0001, 0, 2'd2, 0));
      vt.push_back(mk(4'b0100, 4'b0000, 1, 32'd2,  4'b0100, 1, 32'h2000_0002, 0, 2'd2, 0));
      vt.push_back(mk(4'b0100, 4'b0100, 1, 32'd3,  4'b0100, 1, 32'h2000_0003, 1, 2'd2, 0));
      vt.push_back(mk(4'b0000, 4'b0000, 1, 32'd0,  4'b0000, 0, 32'h0,         0, 2'd2, 0));
      // simultaneous 1-flit requests on inputs 1 and 3
      vt.push_back(mk(4'b1010, 4'b1010, 1, 32'd5,  4'b0000, 0, 32'h0,         0, 2'd1, 0));
      vt.push_back(mk(4'b1010, 4'b1010, 1, 32'd5,  4'b0010, 1, 32'h1000_0005, 1, 2'd1, 0));
      vt.push_back(mk(4'b1000, 4'b1000, 1, 32'd5,  4'b0000, 0, 32'h0,         0, 2'd3, 0));
      vt.push_back(mk(4'b1000, 4'b1000, 1, 32'd5,  4'b1000, 1, 32'h3000_0005, 1, 2'd3, 0));
      vt.push_back(mk(4'b0000, 4'b0000, 1, 32'd0,  4'b0000, 0, 32'h0,         0, 2'd3, 0));
      // downstream stall for 3 cycles on input 0
      vt.push_back(mk(4'b0001, 4'b0000, 1, 32'd10, 4'b0000, 0, 32'h0,         0, 2'd0, 0));
      vt.push_back(mk(4'b0001, 4'b0000, 1, 32'd11, 4'b0001, 1, 32'h0000_000B, 0, 2'd0, 0));
      vt.push_back(mk(4'b0001, 4'b0000, 0, 32'd12, 4'b0000, 1, 32'h0000_000B, 0, 2'd0, 0));
      vt.push_back(mk(4'b0001, 4'b0000, 0, 32'd12, 4'b0000, 1, 32'h0000_000B, 0, 2'd0, 0));
      vt.push_back(mk(4'b0001, 4'b0000, 0, 32'd12, 4'b0000, 1, 32'h0000_000B, 0, 2'd0, 0));
      vt.push_back(mk(4'b0001, 4'b0000, 1, 32'd12, 4'b0001, 1, 32'h0000_000C, 0, 2'd0, 0));
      vt.push_back(mk(4'b0001, 4'b0001, 1, 32'd13, 4'b0001, 1, 32'h0000_000D, 1, 2'd0, 0));
      vt.push_back(mk(4'b0000, 4'b0000, 1, 32'd0,  4'b0000, 0, 32'h0,         0, 2'd0, 0));
      // owner 2 drops valid for 2 cycles while input 0 requests
      vt.push_back(mk(4'b0100, 4'b0000, 1, 32'd20, 4'b0000, 0, 32'h0,         0, 2'd2, 0));
      vt.push_back(mk(4'b0100, 4'b0000, 1, 32'd20, 4'b0100, 1, 32'h2000_0014, 0, 2'd2, 0));
      vt.push_back(mk(4'b0001, 4'b0000, 1, 32'd21, 4'b0100, 0, 32'h0,         0, 2'd2, 0));
      vt.push_back(mk(4'b0001, 4'b0000, 1, 32'd21, 4'b0100, 0, 32'h0,         0, 2'd2, 0));
      vt.push_back(mk(4'b0101, 4'b0100, 1, 32'd21, 4'b0100, 1, 32'h2000_0015, 1, 2'd2, 0));
      vt.push_back(mk(4'b0001, 4'b0001, 1, 32'd22, 4'b0000, 0, 32'h0,         0, 2'd0, 0));
      vt.push_back(mk(4'b0001, 4'b0001, 1, 32'd22, 4'b0001, 1, 32'h0000_0016, 1, 2'd0, 0));
      vt.push_back(mk(4'b0000, 4'b0000, 1, 32'd0,  4'b0000, 0, 32'h0,         0, 2'd0, 0));
      // overlong packet on input 3, watchdog at 4 flits
      vt.push_back(mk(4'b1000, 4'b0000, 1, 32'd30, 4'b0000, 0, 32'h0,         0, 2'd3, 0));
      vt.push_back(mk(4'b1000, 4'b0000, 1, 32'd31, 4'b1000, 1, 32'h3000_001F, 0, 2'd3, 0));
      vt.push_back(mk(4'b1000, 4'b0000, 1, 32'd32, 4'b1000, 1, 32'h3000_0020, 0, 2'd3, 0));
      vt.push_back(mk(4'b1000, 4'b0000, 1, 32'd33, 4'b1000, 1, 32'h3000_0021, 0, 2'd3, 0));
      vt.push_back(mk(4'b1000, 4'b0000, 1, 32'd34, 4'b1000, 1, 32'h3000_0022, 0, 2'd3, 1));
      vt.push_back(mk(4'b0000, 4'b0000, 1, 32'd0,  4'b0000, 0, 32'h0,         0, 2'd3, 1));
      vt.push_back(mk(4'b0000, 4'b0000, 1, 32'd0,  4'b0000, 0, 32'h0,         0, 2'd3, 1));

      // reset state
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd0);
      chk("reset owner", 32'(owner), 32'd0);
      chk("reset err", 32'(err_overlong), 32'd0);
      chk("reset out_data", out_data, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      foreach (vt[k]) begin
         drive(vt[k].v, vt[k].l, vt[k].d);
         out_ready = vt[k].ordy;
         #1;
         chk($sformatf("row%0d in_ready", k), 32'(in_ready), 32'(vt[k].e_ir));
         @(posedge clk);
         #1;
         chk($sformatf("row%0d out_valid", k), 32'(out_valid), 32'(vt[k].e_ov));
         chk($sformatf("row%0d owner", k), 32'(owner), 32'(vt[k].e_own));
         chk($sformatf("row%0d err", k), 32'(err_overlong), 32'(vt[k].e_err));
         if (vt[k].e_ov) begin
            chk($sformatf("row%0d out_data", k), out_data, vt[k].e_od);
            chk($sformatf("row%0d out_last", k), 32'(out_last), 32'(vt[k].e_ol));
         end
      end

      // asynchronous reset during flit 2 of an input-1 packet
      drive(4'b0010, 4'b0000, 32'd40);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("arst lock owner", 32'(owner), 32'd1);
      @(posedge clk); #1;
      chk("arst flit1 data", out_data, 32'h1000_0028);
      drive(4'b0010, 4'b0000, 32'd41);
      #1;
      chk("arst pre in_ready", 32'(in_ready), 32'b0010);
      chk("arst pre err", 32'(err_overlong), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("arst out_valid", 32'(out_valid), 32'd0);
      chk("arst in_ready", 32'(in_ready), 32'd0);
      chk("arst err", 32'(err_overlong), 32'd0);
      chk("arst owner", 32'(owner), 32'd0);
      drive(4'b0000, 4'b0000, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      drive(4'b0100, 4'b0100, 32'd50);
      @(posedge clk); #1;
      chk("post-reset owner", 32'(owner), 32'd2);
      chk("post-reset idle out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("post-reset out_valid", 32'(out_valid), 32'd1);
      chk("post-reset out_data", out_data, 32'h2000_0032);
      chk("post-reset out_last", 32'(out_last), 32'd1);
      drive(4'b0000, 4'b0000, 32'd0);
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/output_port_ctrl.md
Name: output_port_ctrl

Overview:
- Output-port controller for one router output; the stage directly downstream of four_way_arbiter.
- Collects flit requests from the four input buffers and drives the arbiter's request vector.
- Locks the winning input for a whole packet (wormhole) and forwards its flits through a registered output stage with a valid/ready handshake to the link or next router.

Parameters:
DATA_W, 32, flit payload width in bits
MAX_FLITS, 16, max flits per packet; the packet watchdog releases the lock at this count
CNT_W, $clog2(MAX_FLITS+1), flit counter width (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  4  per-input flit valid; also the arbitration request
in_data  in  4*DATA_W  flit payloads; input i occupies bits [i*DATA_W +: DATA_W]
in_last  in  4  per-input tail-flit marker
in_ready  out  4  per-input accept; at most one bit high at a time
out_valid  out  1  registered output flit valid
out_data  out  DATA_W  registered output flit
out_last  out  1  registered tail marker
out_ready  in  1  downstream accept
owner  out  2  currently locked input index (debug)
err_overlong  out  1  sticky error; packet exceeded MAX_FLITS

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, owner=0, flit_cnt=0, out_valid=0, out_data=0, out_last=0, err_overlong=0, in_ready=0.
- Arbiter hookup: four_way_arbiter is instantiated with requests=arb_req and reset=~reset. Its granted output is used only when |arb_req.
- arb_req is in_valid when OPC_RR_MASK_EN is off.
- The arbiter is fixed priority: the lowest-numbered asserted request wins.
- Output stage: can_load = !out_valid || out_ready.
- FSM IDLE:
  - in_ready=0.
  - If |arb_req: owner<=granted, flit_cnt<=0, next state LOCKED.
  - Otherwise stay in IDLE.
- FSM LOCKED:
  - in_ready[owner]=can_load; all other in_ready bits are 0.
  - A transfer occurs when in_valid[owner] && can_load.
  - On transfer: out_data<=in_data[owner], out_last<=in_last[owner], out_valid<=1, flit_cnt<=flit_cnt+1.
  - If a transferred flit has in_last=1, go to IDLE.
- Output register: if out_ready && out_valid and no transfer occurs that cycle, out_valid<=0. A load and a drain in the same cycle keep out_valid=1 (full throughput, 1 flit/cycle).
- Latency:
  - Request asserted in cycle 0 → lock at edge 1.
  - First flit accepted in cycle 1 → out_valid high from edge 2.
  - After the tail, IDLE costs one cycle before the next arbitration; the minimum gap between packets is 1 bubble.
- Owner stall: if in_valid[owner] drops mid-packet, the lock is held indefinitely and no other input is served.
- Downstream stall: out_ready=0 with out_valid=1 forces in_ready=0. out_data and out_last hold stable.
- Watchdog: if a transfer brings flit_cnt to MAX_FLITS without in_last, the flit is still forwarded. The controller then sets err_overlong=1 (sticky until reset) and returns to IDLE. out_last is not forced.
- Single-flit packet (in_last=1 on the first flit): LOCKED lasts exactly one transfer.
- Simultaneous requests in IDLE: one winner per the arbiter; losers stay pending with in_ready=0.
- Reset mid-packet clears everything asynchronously; the partial packet is dropped and upstream buffers reset in parallel.

Optional Feature:
- Macro: OPC_RR_MASK_EN.
- Defined:
  - A 4-bit priority mask is kept and updated on every return to IDLE (tail or watchdog) to exclude the just-served input and all lower-numbered inputs.
  - arb_req = (in_valid & mask) when that is non-zero, else in_valid.
  - Effective round-robin with the same arbiter. The mask resets to 4'b1111.
- Undefined: no mask; pure fixed priority (input 0 can starve the others).

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=1'b0, LOCKED=1'b1).
  - Port index constants (PORT0..PORT3 = 2'd0..2'd3).
  - The default DATA_W and MAX_FLITS.
- One sub-module: the existing four_way_arbiter, instantiated unchanged. Flit mux, FSM, counter and output register live in output_port_ctrl.

Test Plan:
- Reset then in_valid=4'b0100, 3-flit packet on input 2 (last on flit 3), out_ready=1 → owner=2 at edge 1; out_valid from edge 2; flits emerge back-to-back in order, out_last on the third; FSM back in IDLE.
- in_valid=4'b1010 simultaneously, 1-flit packets, out_ready=1:
  - Macro off → input 1 served first, then input 3.
  - Macro on → same first, then input 3; input 1 re-requesting does not preempt input 3.
- Mid-packet out_ready=0 for 3 cycles → in_ready[owner]=0; out_data/out_last stable; no flit lost or duplicated after out_ready=1.
- Owner drops in_valid for 2 cycles mid-packet while input 0 requests → lock held; in_ready[0]=0 throughout; packet completes before input 0 is granted.
- MAX_FLITS=4, packet of 6 flits without tail → 4 flits forwarded, err_overlong=1 after the 4th, FSM IDLE; err_overlong stays 1 until reset.
- Assert reset=0 during flit 2 → out_valid, in_ready, err_overlong go 0 immediately; after release, a new request is arbitrated normally.
